// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map, pass signature and status word layout for the MMIO console
package mmio_pkg;

  localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] MMIO_STATUS_ADDR  = 32'h1000_0004;
  localparam logic [31:0] MMIO_PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] MMIO_PASS_MAGIC   = 32'd123456789;
  localparam logic [31:0] MMIO_BAD_RDATA    = 32'hDEAD_BEEF;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_LEVEL_LSB = 16;

  typedef enum logic [1:0] {
    REG_CONSOLE,
    REG_STATUS,
    REG_PASS,
    REG_NONE
  } mmio_reg_e;

  function automatic logic [31:0] status_word(input logic [15:0] level,
                                              input logic        full,
                                              input logic        empty);
    logic [31:0] w;
    w = '0;
    w[STATUS_LEVEL_LSB +: 16] = level;
    w[STATUS_FULL_BIT]        = full;
    w[STATUS_EMPTY_BIT]       = empty;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_level, w_level_nxt;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + 1'b1;
    else if (w_pop && !w_push)
      w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers are AW bits wide, so power-of-two depth wraps for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LEVEL);
      r_empty <= (w_level_nxt == '0);
    end
  end

endmodule

// File: rtl/axi_mmio_console.sv
// rtl/axi_mmio_console.sv - AXI4-Lite MMIO slave: console byte FIFO, sticky pass flag, status word
module axi_mmio_console
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] CONSOLE_ADDR = MMIO_CONSOLE_ADDR,
  parameter logic [31:0] STATUS_ADDR  = MMIO_STATUS_ADDR,
  parameter logic [31:0] PASS_ADDR    = MMIO_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC   = MMIO_PASS_MAGIC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        tests_passed,
  output logic        bus_error
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic            r_tests_passed, r_bus_error;
  logic [31:0]     r_aw_addr, r_w_data, r_rdata;
  logic [3:0]      r_w_strb;
  logic            w_fifo_full, w_fifo_empty;
  logic            w_stall, w_commit, w_push;
  logic [LW-1:0]   w_level;
  logic [31:0]     w_rdata_nxt;
  logic            w_rd_unmapped;
  mmio_reg_e       w_wr_reg, w_rd_reg;
  logic            w_unused;

  function automatic mmio_reg_e decode(input logic [31:0] a);
    if (a == CONSOLE_ADDR) return REG_CONSOLE;
    if (a == STATUS_ADDR)  return REG_STATUS;
    if (a == PASS_ADDR)    return REG_PASS;
    return REG_NONE;
  endfunction

  assign w_unused = ^{mem_axi_awprot, mem_axi_arprot};
  assign w_wr_reg = decode(r_aw_addr);
  assign w_rd_reg = decode(mem_axi_araddr);

  assign mem_axi_awready = !reset && !r_aw_held && !r_bvalid;
  assign mem_axi_wready  = !reset && !r_w_held && !r_bvalid;
  assign mem_axi_arready = !reset && !r_rvalid;
  assign mem_axi_bvalid  = r_bvalid;
  assign mem_axi_rvalid  = r_rvalid;
  assign mem_axi_rdata   = r_rdata;
  assign out_valid       = !w_fifo_empty;
  assign tests_passed    = r_tests_passed;
  assign bus_error       = r_bus_error;

  // A console byte into a full FIFO holds the commit, back-pressuring the CPU via B.
  assign w_stall  = (w_wr_reg == REG_CONSOLE) && w_fifo_full && r_w_strb[0];
  assign w_commit = r_aw_held && r_w_held && !w_stall;
  assign w_push   = w_commit && (w_wr_reg == REG_CONSOLE) && r_w_strb[0];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_w_data[7:0]),
    .i_pop   (out_ready),
    .o_data  (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_rdata_nxt   = '0;
    w_rd_unmapped = 1'b0;
    case (w_rd_reg)
      REG_CONSOLE: w_rdata_nxt = '0;
      REG_STATUS:  w_rdata_nxt = status_word(16'(w_level), w_fifo_full, w_fifo_empty);
      REG_PASS:    w_rdata_nxt = {31'b0, r_tests_passed};
      REG_NONE: begin
        w_rdata_nxt   = MMIO_BAD_RDATA;
        w_rd_unmapped = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_held      <= 1'b0;
      r_w_held       <= 1'b0;
      r_aw_addr      <= '0;
      r_w_data       <= '0;
      r_w_strb       <= '0;
      r_bvalid       <= 1'b0;
      r_rvalid       <= 1'b0;
      r_rdata        <= '0;
      r_tests_passed <= 1'b0;
      r_bus_error    <= 1'b0;
    end else begin
      if (mem_axi_awvalid && mem_axi_awready) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        r_w_held <= 1'b1;
        r_w_data <= mem_axi_wdata;
        r_w_strb <= mem_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_wr_reg == REG_PASS && r_w_strb == 4'hF && r_w_data == PASS_MAGIC)
          r_tests_passed <= 1'b1;
        if (w_wr_reg == REG_STATUS || w_wr_reg == REG_NONE)
          r_bus_error <= 1'b1;
      end else if (r_bvalid && mem_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (mem_axi_arvalid && mem_axi_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_nxt;
        if (w_rd_unmapped)
          r_bus_error <= 1'b1;
      end else if (r_rvalid && mem_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule
